// File: rtl/alu8_nibble_sequencer.sv
// alu8_nibble_sequencer: runs one 8-bit op as two 4-bit slice passes with a chained carry; ALU8_FLAGS_EN adds out_zero
module alu8_nibble_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_cin,
  input  logic [2:0] in_s,
  output logic [3:0] slice_a,
  output logic [3:0] slice_b,
  output logic       slice_cin,
  output logic [2:0] slice_s,
  input  logic [3:0] slice_out,
  input  logic       slice_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_cout
`ifdef ALU8_FLAGS_EN
  ,
  output logic       out_zero
`endif
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] a_q, b_q, res_q;
  logic [2:0] s_q;
  logic cin_q, carry_q, cout_q;
  logic lo, hi;
  assign lo = state == LO;
  assign hi = state == HI;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_result = res_q;
  assign out_cout = cout_q;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (in_valid ? LO : IDLE) :
               (state == LO)   ? HI :
               (state == HI)   ? DONE :
               (out_ready ? IDLE : DONE);
    slice_a = lo ? a_q[3:0] : hi ? a_q[7:4] : 4'd0;
    slice_b = lo ? b_q[3:0] : hi ? b_q[7:4] : 4'd0;
    slice_cin = lo ? cin_q : hi ? carry_q : 1'b0;
    slice_s = (lo || hi) ? s_q : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      cin_q <= 1'b0;
      carry_q <= 1'b0;
      res_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_ready && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
        cin_q <= in_cin;
        s_q <= in_s;
      end
      if (lo) begin
        res_q[3:0] <= slice_out;
        carry_q <= slice_cout;
      end
      if (hi) begin
        res_q[7:4] <= slice_out;
        cout_q <= slice_cout;
      end
    end
  end
`ifdef ALU8_FLAGS_EN
  logic zero_q;
  assign out_zero = zero_q;
  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else if (hi) zero_q <= {slice_out, res_q[3:0]} == 8'd0;
  end
`endif
endmodule
